// File: rtl/protector_lock.sv
// protector_lock: keypad arm/disarm guard fed by PS/2 scan codes.
// Entering the stored CODE_LEN-digit code toggles the armed bit. The code
// can be reprogrammed at runtime while disarmed. Break (key release)
// sequences are filtered, Esc aborts an entry, and repeated wrong codes
// trigger a timed lockout.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   ps2_data      received scan code, qualified by ps2_new_data
//   ps2_new_data  one-cycle strobe per received byte
//   prog_req      one-cycle request to load a new code (disarmed only)
//   on_out        armed
//   off_out       disarmed (always ~on_out)
//   prog_out      programming mode active
//   lock_out      lockout active
//   match_pulse   one-cycle strobe: correct code accepted / new code stored
//   fail_pulse    one-cycle strobe: wrong code rejected
//
// state   | meaning
// ENTRY   | collecting digits of the unlock code
// PROG    | collecting digits of a new code into the shadow register
// LOCKOUT | input ignored until the lock counter expires
module protector_lock #(
  parameter int                           CODE_LEN     = 4,
  parameter int                           DATA_W       = 8,
  parameter logic [CODE_LEN*DATA_W-1:0]   DEFAULT_CODE = 32'h7373747A,
  parameter logic [DATA_W-1:0]            BREAK_CODE   = 8'hF0,
  parameter logic [DATA_W-1:0]            CANCEL_CODE  = 8'h76,
  parameter int                           MAX_FAILS    = 3,
  parameter int                           LOCK_CYCLES  = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ps2_data,
  input  logic              ps2_new_data,
  input  logic              prog_req,
  output logic              on_out,
  output logic              off_out,
  output logic              prog_out,
  output logic              lock_out,
  output logic              match_pulse,
  output logic              fail_pulse
);

  localparam int CODE_W = CODE_LEN * DATA_W;
  localparam int IDX_W  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(CODE_LEN - 1);
  localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAILS - 1);
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [CODE_W-1:0] TOP_MASK  = CODE_W'({DATA_W{1'b1}}) << (CODE_W - DATA_W);

  typedef enum logic [1:0] {ENTRY, PROG, LOCKOUT} state_t;

  state_t              state_q, state_nx;
  logic                armed_q, armed_nx;
  logic [CODE_W-1:0]   code_q, code_nx;
  logic [CODE_W-1:0]   shadow_q, shadow_nx;
  logic [IDX_W-1:0]    idx_q, idx_nx;
  logic                mismatch_q, mismatch_nx;
  logic [FAIL_W-1:0]   fails_q, fails_nx;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_nx;
  logic                break_q, break_nx;
  logic                match_q, match_nx;
  logic                fail_q, fail_nx;
  logic                prog_q, lock_q, off_q;

  logic                prog_take;
  logic                digit_valid;
  logic                hit;
  logic [CODE_W-1:0]   code_sh;
  logic [CODE_W-1:0]   slot_mask;
  logic [CODE_W-1:0]   slot_data;

  // Slot [idx] sits at the MSB end for idx=0; shift it to the top to read,
  // and shift a top-aligned mask/digit down to write.
  always_comb begin
    code_sh   = code_q << (int'(idx_q) * DATA_W);
    hit       = (code_sh[CODE_W-1 -: DATA_W] == ps2_data);
    slot_mask = TOP_MASK >> (int'(idx_q) * DATA_W);
    slot_data = (CODE_W'(ps2_data) << (CODE_W - DATA_W)) >> (int'(idx_q) * DATA_W);
  end

  always_comb begin
    state_nx    = state_q;
    armed_nx    = armed_q;
    code_nx     = code_q;
    shadow_nx   = shadow_q;
    idx_nx      = idx_q;
    mismatch_nx = mismatch_q;
    fails_nx    = fails_q;
    lock_cnt_nx = lock_cnt_q;
    break_nx    = break_q;
    match_nx    = 1'b0;
    fail_nx     = 1'b0;
    digit_valid = 1'b0;

    // A taken prog_req swallows any byte arriving in the same cycle.
    prog_take = prog_req && (state_q == ENTRY) && !armed_q;

    if ((state_q != LOCKOUT) && ps2_new_data && !prog_take) begin
      if (break_q)
        break_nx = 1'b0;
      else if (ps2_data == BREAK_CODE)
        break_nx = 1'b1;
      else
        digit_valid = 1'b1;
    end

    case (state_q)
      ENTRY: begin
        if (prog_take) begin
          state_nx    = PROG;
          idx_nx      = '0;
          mismatch_nx = 1'b0;
        end else if (digit_valid) begin
          if (ps2_data == CANCEL_CODE) begin
            idx_nx      = '0;
            mismatch_nx = 1'b0;
          end else if (idx_q == LAST_IDX) begin
            idx_nx      = '0;
            mismatch_nx = 1'b0;
            if (hit && !mismatch_q) begin
              armed_nx = !armed_q;
              match_nx = 1'b1;
              fails_nx = '0;
            end else begin
              fail_nx  = 1'b1;
              fails_nx = fails_q + FAIL_W'(1);
              if (fails_q == FAIL_LAST) begin
                state_nx    = LOCKOUT;
                lock_cnt_nx = LOCK_LOAD;
              end
            end
          end else begin
            idx_nx      = idx_q + IDX_W'(1);
            mismatch_nx = mismatch_q || !hit;
          end
        end
      end
      PROG: begin
        if (digit_valid) begin
          if (ps2_data == CANCEL_CODE) begin
            state_nx = ENTRY;
            idx_nx   = '0;
          end else begin
            shadow_nx = (shadow_q & ~slot_mask) | slot_data;
            if (idx_q == LAST_IDX) begin
              code_nx  = shadow_nx;
              match_nx = 1'b1;
              state_nx = ENTRY;
              idx_nx   = '0;
            end else begin
              idx_nx = idx_q + IDX_W'(1);
            end
          end
        end
      end
      LOCKOUT: begin
        break_nx = 1'b0;
        if (lock_cnt_q == '0) begin
          state_nx    = ENTRY;
          fails_nx    = '0;
          idx_nx      = '0;
          mismatch_nx = 1'b0;
        end else begin
          lock_cnt_nx = lock_cnt_q - LOCK_W'(1);
        end
      end
      default: state_nx = ENTRY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ENTRY;
      armed_q    <= 1'b0;
      code_q     <= DEFAULT_CODE;
      shadow_q   <= '0;
      idx_q      <= '0;
      mismatch_q <= 1'b0;
      fails_q    <= '0;
      lock_cnt_q <= '0;
      break_q    <= 1'b0;
      match_q    <= 1'b0;
      fail_q     <= 1'b0;
      prog_q     <= 1'b0;
      lock_q     <= 1'b0;
      off_q      <= 1'b1;
    end else begin
      state_q    <= state_nx;
      armed_q    <= armed_nx;
      code_q     <= code_nx;
      shadow_q   <= shadow_nx;
      idx_q      <= idx_nx;
      mismatch_q <= mismatch_nx;
      fails_q    <= fails_nx;
      lock_cnt_q <= lock_cnt_nx;
      break_q    <= break_nx;
      match_q    <= match_nx;
      fail_q     <= fail_nx;
      prog_q     <= (state_nx == PROG);
      lock_q     <= (state_nx == LOCKOUT);
      off_q      <= !armed_nx;
    end
  end

  assign on_out      = armed_q;
  assign off_out     = off_q;
  assign prog_out    = prog_q;
  assign lock_out    = lock_q;
  assign match_pulse = match_q;
  assign fail_pulse  = fail_q;

endmodule

// File: tb/tb_protector_lock.sv
module tb_protector_lock;

  localparam logic [1:0] NONE  = 2'b00;
  localparam logic [1:0] MATCH = 2'b10;
  localparam logic [1:0] FAILP = 2'b01;

  localparam logic [31:0] DEF_CODE = 32'h7373747A;
  localparam logic [31:0] NEW_CODE = 32'h161E2625;
  localparam logic [31:0] ALT_CODE = 32'h1C1B232B;
  localparam logic [31:0] BAD_CODE = 32'h11223344;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_new_data = 1'b0;
  logic       prog_req = 1'b0;
  logic       on_out, off_out, prog_out, lock_out, match_pulse, fail_pulse;

  protector_lock #(
    .CODE_LEN(4), .DATA_W(8), .DEFAULT_CODE(32'h7373747A),
    .BREAK_CODE(8'hF0), .CANCEL_CODE(8'h76), .MAX_FAILS(3), .LOCK_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .ps2_data(ps2_data), .ps2_new_data(ps2_new_data),
    .prog_req(prog_req), .on_out(on_out), .off_out(off_out), .prog_out(prog_out),
    .lock_out(lock_out), .match_pulse(match_pulse), .fail_pulse(fail_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [1:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_cmp = 0;
  int  n_err = 0;

  // One cycle of stimulus. Pulse expectations become due on the posedge that
  // samples the stimulus and are popped on the following negedge.
  task automatic drive(input logic nd, input logic [7:0] d, input logic pr, input logic [1:0] exp);
    sb_t e;
    @(negedge clk);
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      n_cmp++;
      if ({match_pulse, fail_pulse} !== e.exp) begin
        n_err++;
        $display("FAIL scoreboard_pulses cyc=%0d got {match,fail}=%b expected %b", cyc, {match_pulse, fail_pulse}, e.exp);
      end
    end
    @(posedge clk);
    #1;
    ps2_new_data = nd;
    ps2_data     = d;
    prog_req     = pr;
    sb.push_back('{cyc + 1, exp});
  endtask

  task automatic send(input logic [7:0] b, input logic [1:0] exp);
    drive(1'b1, b, 1'b0, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, NONE);
  endtask

  task automatic send_code(input logic [31:0] c, input logic [1:0] last);
    for (int i = 0; i < 4; i++) send(c[31-8*i -: 8], (i == 3) ? last : NONE);
  endtask

  task automatic request_prog();
    drive(1'b0, 8'h00, 1'b1, NONE);
  endtask

  task automatic apply_reset();
    drive(1'b0, 8'h00, 1'b0, NONE);
    @(posedge clk);
    #2;
    reset = 1'b0;
    sb.delete();
    #1;
    n_cmp++; if (on_out !== 1'b0)   begin n_err++; $display("FAIL async_reset_on got %b expected 0", on_out); end
    n_cmp++; if (off_out !== 1'b1)  begin n_err++; $display("FAIL async_reset_off got %b expected 1", off_out); end
    n_cmp++; if (prog_out !== 1'b0) begin n_err++; $display("FAIL async_reset_prog got %b expected 0", prog_out); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (on_out !== 1'b0)      begin n_err++; $display("FAIL reset_on got %b expected 0", on_out); end
    n_cmp++; if (off_out !== 1'b1)     begin n_err++; $display("FAIL reset_off got %b expected 1", off_out); end
    n_cmp++; if (prog_out !== 1'b0)    begin n_err++; $display("FAIL reset_prog got %b expected 0", prog_out); end
    n_cmp++; if (lock_out !== 1'b0)    begin n_err++; $display("FAIL reset_lock got %b expected 0", lock_out); end
    n_cmp++; if (match_pulse !== 1'b0) begin n_err++; $display("FAIL reset_match got %b expected 0", match_pulse); end
    n_cmp++; if (fail_pulse !== 1'b0)  begin n_err++; $display("FAIL reset_fail got %b expected 0", fail_pulse); end
    reset = 1'b1;
  endtask

  task automatic test_arm_toggle();
    send_code(DEF_CODE, MATCH);
    idle(1);
    n_cmp++; if (on_out !== 1'b1)  begin n_err++; $display("FAIL arm_on got %b expected 1", on_out); end
    n_cmp++; if (off_out !== 1'b0) begin n_err++; $display("FAIL arm_off got %b expected 0", off_out); end
    send_code(DEF_CODE, MATCH);
    idle(1);
    n_cmp++; if (on_out !== 1'b0)  begin n_err++; $display("FAIL disarm_on got %b expected 0", on_out); end
    n_cmp++; if (off_out !== 1'b1) begin n_err++; $display("FAIL disarm_off got %b expected 1", off_out); end
  endtask

  task automatic test_break_filter();
    send(8'h73, NONE);
    send(8'hF0, NONE);
    send(8'h73, NONE);
    send(8'h73, NONE);
    send(8'h74, NONE);
    send(8'h7A, MATCH);
    idle(1);
    n_cmp++; if (on_out !== 1'b1) begin n_err++; $display("FAIL break_filter_on got %b expected 1", on_out); end
  endtask

  task automatic test_lockout();
    int lk;
    send_code(BAD_CODE, FAILP);
    send_code(BAD_CODE, FAILP);
    n_cmp++; if (lock_out !== 1'b0) begin n_err++; $display("FAIL lock_early got %b expected 0", lock_out); end
    send_code(BAD_CODE, FAILP);
    idle(1);
    n_cmp++; if (lock_out !== 1'b1) begin n_err++; $display("FAIL lock_rise got %b expected 1", lock_out); end
    lk = (lock_out === 1'b1) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      send(DEF_CODE[31-8*i -: 8], NONE);
      if (lock_out === 1'b1) lk++;
    end
    for (int i = 0; i < 40 && lock_out === 1'b1; i++) begin
      idle(1);
      if (lock_out === 1'b1) lk++;
    end
    n_cmp++; if (lk != 16) begin n_err++; $display("FAIL lock_duration got %0d cycles expected 16", lk); end
    n_cmp++; if (on_out !== 1'b1) begin n_err++; $display("FAIL lock_armed_kept got %b expected 1", on_out); end
    send_code(DEF_CODE, MATCH);
    idle(1);
    n_cmp++; if (on_out !== 1'b0) begin n_err++; $display("FAIL after_lock_match_on got %b expected 0", on_out); end
  endtask

  task automatic test_cancel();
    send(8'h73, NONE);
    send(8'h73, NONE);
    send(8'h76, NONE);
    send_code(DEF_CODE, MATCH);
    idle(1);
    n_cmp++; if (on_out !== 1'b1) begin n_err++; $display("FAIL cancel_on got %b expected 1", on_out); end
    request_prog();
    idle(1);
    n_cmp++; if (prog_out !== 1'b0) begin n_err++; $display("FAIL prog_while_armed got %b expected 0", prog_out); end
    // Two further failures must not lock out if the cancel left the count at 0.
    send_code(BAD_CODE, FAILP);
    send_code(BAD_CODE, FAILP);
    idle(1);
    n_cmp++; if (lock_out !== 1'b0) begin n_err++; $display("FAIL cancel_fail_count got lock %b expected 0", lock_out); end
    send_code(DEF_CODE, MATCH);
    idle(1);
    n_cmp++; if (on_out !== 1'b0) begin n_err++; $display("FAIL cancel_final_on got %b expected 0", on_out); end
  endtask

  task automatic test_program();
    request_prog();
    send(8'h16, NONE);
    n_cmp++; if (prog_out !== 1'b1) begin n_err++; $display("FAIL prog_rise got %b expected 1", prog_out); end
    send(8'h1E, NONE);
    n_cmp++; if (prog_out !== 1'b1) begin n_err++; $display("FAIL prog_hold1 got %b expected 1", prog_out); end
    send(8'h26, NONE);
    n_cmp++; if (prog_out !== 1'b1) begin n_err++; $display("FAIL prog_hold2 got %b expected 1", prog_out); end
    send(8'h25, MATCH);
    n_cmp++; if (prog_out !== 1'b1) begin n_err++; $display("FAIL prog_hold3 got %b expected 1", prog_out); end
    idle(1);
    n_cmp++; if (prog_out !== 1'b0) begin n_err++; $display("FAIL prog_fall got %b expected 0", prog_out); end
    n_cmp++; if (on_out !== 1'b0)   begin n_err++; $display("FAIL prog_no_arm got %b expected 0", on_out); end
    send_code(DEF_CODE, FAILP);
    send_code(NEW_CODE, MATCH);
    idle(1);
    n_cmp++; if (on_out !== 1'b1) begin n_err++; $display("FAIL new_code_on got %b expected 1", on_out); end
  endtask

  task automatic test_reset_mid();
    send(8'h16, NONE);
    send(8'h1E, NONE);
    apply_reset();
    send_code(DEF_CODE, MATCH);
    send_code(DEF_CODE, MATCH);
    request_prog();
    send(8'h16, NONE);
    send(8'h1E, NONE);
    send(8'h26, NONE);
    apply_reset();
    send_code(DEF_CODE, MATCH);
    send_code(DEF_CODE, MATCH);
    request_prog();
    send_code(ALT_CODE, MATCH);
    apply_reset();
    send_code(ALT_CODE, FAILP);
    send_code(DEF_CODE, MATCH);
    idle(1);
    n_cmp++; if (on_out !== 1'b1) begin n_err++; $display("FAIL reset_restores_code got %b expected 1", on_out); end
  endtask

  initial begin
    test_reset();
    test_arm_toggle();
    test_break_filter();
    test_lockout();
    test_cancel();
    test_program();
    test_reset_mid();
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/protector_lock.md
# protector_lock

Parametrised successor of the keypad arm/disarm protector. It consumes PS/2 scan-code bytes from the keyboard receiver and toggles an armed/disarmed state when a CODE_LEN-digit code is entered correctly. Additions over the previous generation:
- runtime-programmable code register
- PS/2 break-code filtering
- cancel key
- lockout after repeated failures

It sits between the PS/2 receiver and the alarm/LED logic.

## Interface
- CODE_LEN, 4: digits per code (≥1)
- DATA_W, 8: scan-code width
- DEFAULT_CODE, 32'h7373747A: reset code, digit 1 in MSBs (keypad 5,5,6,3), width CODE_LEN*DATA_W
- BREAK_CODE, 8'hF0: release prefix
- CANCEL_CODE, 8'h76: Esc, aborts entry
- MAX_FAILS, 3: consecutive wrong codes before lockout (≥1)
- LOCK_CYCLES, 50_000_000: lockout duration in clk cycles (≥1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; one clock; all state cleared while low
- ps2_data  in  DATA_W  received scan code, valid when ps2_new_data=1
- ps2_new_data  in  1  one-cycle strobe per received byte
- prog_req  in  1  one-cycle request to load a new code
- on_out  out  1  armed
- off_out  out  1  disarmed, always ~on_out
- prog_out  out  1  programming mode active
- lock_out  out  1  lockout active
- match_pulse  out  1  one-cycle strobe, correct code accepted
- fail_pulse  out  1  one-cycle strobe, wrong code rejected

## Operation
- Main FSM states: ENTRY, PROG, LOCKOUT. The armed bit, code register, digit index (0..CODE_LEN-1), mismatch flag, fail counter, lock counter and break_pending flag are separate registers.
- Reset values: state=ENTRY, armed=0 (on_out=0, off_out=1), code=DEFAULT_CODE, index=0, mismatch=0, fails=0, break_pending=0, prog_out=0, lock_out=0, pulses=0.
- Byte filter applies in ENTRY and PROG on each ps2_new_data:
  - BREAK_CODE sets break_pending and is otherwise discarded.
  - The next byte with break_pending=1 clears break_pending and is discarded.
  - Any other byte is a digit.
- ENTRY:
  - CANCEL_CODE digit: index=0, mismatch=0, no pulse, fail count unchanged.
  - Other digit: compared with code slice [index]; a difference sets mismatch; index increments.
  - On the CODE_LEN-th digit, index returns to 0.
  - Digit matches and mismatch=0: armed toggles, match_pulse, fails=0.
  - Otherwise: fail_pulse, fails+1. If fails reaches MAX_FAILS, go to LOCKOUT with the counter loaded with LOCK_CYCLES-1.
- PROG:
  - Entered only from ENTRY when prog_req=1 and armed=0. This aborts any partial entry (index=0, mismatch=0).
  - prog_req while armed=1, or in PROG or LOCKOUT, is ignored.
  - Each digit is written to a shadow register slot [index]. CANCEL_CODE returns to ENTRY with the code unchanged.
  - On the CODE_LEN-th digit the shadow copies to the code register, match_pulse fires, and the FSM returns to ENTRY with index=0.
- LOCKOUT:
  - All bytes and prog_req are ignored; break_pending is cleared.
  - The counter decrements each cycle. At 0: ENTRY, fails=0, index=0.
  - armed is unchanged.
- prog_req and ps2_new_data in the same cycle: prog_req is taken and the byte is discarded.
- Counter widths: index $clog2(CODE_LEN) (min 1), fails $clog2(MAX_FAILS+1), lock $clog2(LOCK_CYCLES) (min 1). No wrap: fails saturates by leaving for LOCKOUT.

## Timing
- All outputs are registered.
- on_out/off_out and match_pulse/fail_pulse update on the edge that samples the final digit's strobe, and are visible the following cycle.
- The pulses are exactly one cycle wide. Each accepted byte causes at most one pulse.
- prog_out rises the cycle after prog_req is accepted. It falls with match_pulse on commit, or the cycle after the cancel byte.
- lock_out rises together with the fail_pulse that triggers lockout and stays high exactly LOCK_CYCLES cycles.
- Back-to-back strobes on consecutive cycles are all processed; there is no input buffering.
- Reset asserted mid-operation abandons entry and programming and restores DEFAULT_CODE immediately, asynchronously.

## Test plan
(Parameters: CODE_LEN=4, MAX_FAILS=3, LOCK_CYCLES=16)
- Reset, bytes 73,73,74,7A → match_pulse 1 cycle, on_out=1/off_out=0; same sequence again → on_out=0.
- Bytes 73,F0,73,73,74,7A → break and its released byte ignored, match, on_out=1.
- Three wrong codes 11,22,33,44 → three fail_pulse; the third raises lock_out for 16 cycles. Correct code sent during lockout → no effect. Correct code after lockout → match.
- Disarmed: prog_req, then 16,1E,26,25 → prog_out high 4 bytes, then match_pulse. Old code → fail_pulse. 16,1E,26,25 → on_out=1.
- 73,73,76,73,73,74,7A → cancel clears the partial entry, single match, fails stays 0. prog_req while armed → prog_out stays 0.
- Reset low mid-entry after 73,73 and after programming → code back to 7373747A, on_out=0, index 0.
